// File: rtl/vga_timing_detect.sv
// Measures incoming hsync/vsync/de timing at pixel rate and locks once two
// consecutive frames measure identically; emits line/frame leading-edge strobes.
module vga_timing_detect #(
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             de_in,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic             frame_start,
  output logic             line_start
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + ONE;
  endfunction

  state_t           state;
  logic             hs_q, vs_q;
  logic [CNT_W-1:0] hcnt, hde, vcnt, vact;
  logic [CNT_W-1:0] ref_len, last_len, last_act;
  logic             ref_vld, cons;
  logic [CNT_W-1:0] cand_len, cand_act, cand_vcnt, cand_vact;

  logic             h_edge, v_edge, sat, line_bad;
  logic [CNT_W-1:0] f_len, f_act, f_vact;
  logic             f_cons, f_eq_cand, f_eq_out;

  assign h_edge = (hsync_in == SYNC_POL) && (hs_q != SYNC_POL);
  assign v_edge = (vsync_in == SYNC_POL) && (vs_q != SYNC_POL);
  assign sat    = (hcnt == CMAX) || (hde == CMAX) || (vcnt == CMAX) || (vact == CMAX);

  // Frame summary as seen at a vsync edge: a coincident hsync edge closes its line first.
  assign f_len     = h_edge ? hcnt : last_len;
  assign f_act     = (h_edge && hde != '0) ? hde : last_act;
  assign f_vact    = (h_edge && hde != '0) ? sat_inc(vact) : vact;
  assign f_cons    = cons && (!h_edge || !ref_vld || hcnt == ref_len);
  assign f_eq_cand = (f_len == cand_len) && (f_act == cand_act) &&
                     (vcnt == cand_vcnt) && (f_vact == cand_vact);
  assign f_eq_out  = (f_len == h_total) && (f_act == h_active) &&
                     (vcnt == v_total) && (f_vact == v_active);
  assign line_bad  = h_edge && (hcnt != h_total);

  // Sample registers reset to the active level so a sync held active through reset is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q        <= SYNC_POL;
      vs_q        <= SYNC_POL;
      hcnt        <= '0;
      hde         <= '0;
      vcnt        <= '0;
      vact        <= '0;
      ref_len     <= '0;
      ref_vld     <= 1'b0;
      cons        <= 1'b0;
      last_len    <= '0;
      last_act    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en && h_edge;
      frame_start <= pix_en && v_edge;
      if (pix_en) begin
        hs_q <= hsync_in;
        vs_q <= vsync_in;
        if (h_edge) begin
          hcnt     <= ONE;
          hde      <= de_in ? ONE : '0;
          last_len <= hcnt;
        end else begin
          hcnt <= sat_inc(hcnt);
          if (de_in) hde <= sat_inc(hde);
        end
        if (v_edge) begin
          vcnt     <= h_edge ? ONE : '0;
          vact     <= '0;
          cons     <= 1'b1;
          ref_vld  <= 1'b0;
          last_act <= '0;
        end else if (h_edge) begin
          vcnt <= sat_inc(vcnt);
          vact <= f_vact;
          if (hde != '0) last_act <= hde;
          if (!ref_vld) begin
            ref_len <= hcnt;
            ref_vld <= 1'b1;
          end else if (hcnt != ref_len) begin
            cons <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      locked    <= 1'b0;
      h_total   <= '0;
      h_active  <= '0;
      v_total   <= '0;
      v_active  <= '0;
      cand_len  <= '0;
      cand_act  <= '0;
      cand_vcnt <= '0;
      cand_vact <= '0;
    end else if (pix_en) begin
      if (sat) begin
        state  <= SEARCH;
        locked <= 1'b0;
      end else if (v_edge) begin
        case (state)
          SEARCH: state <= MEASURE;
          MEASURE: begin
            cand_len  <= f_len;
            cand_act  <= f_act;
            cand_vcnt <= vcnt;
            cand_vact <= f_vact;
            if (f_cons) state <= VERIFY;
          end
          VERIFY: begin
            if (f_cons && f_eq_cand) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              h_total  <= cand_len;
              h_active <= cand_act;
              v_total  <= cand_vcnt;
              v_active <= cand_vact;
            end else begin
              cand_len  <= f_len;
              cand_act  <= f_act;
              cand_vcnt <= vcnt;
              cand_vact <= f_vact;
            end
          end
          LOCKED: begin
            // A bad closing line drops to SEARCH, and this same vsync edge then starts MEASURE.
            if (line_bad) begin
              locked <= 1'b0;
              state  <= MEASURE;
            end else if (!(f_cons && f_eq_out)) begin
              locked    <= 1'b0;
              state     <= VERIFY;
              cand_len  <= f_len;
              cand_act  <= f_act;
              cand_vcnt <= vcnt;
              cand_vact <= f_vact;
            end
          end
        endcase
      end else if (state == LOCKED && line_bad) begin
        locked <= 1'b0;
        state  <= SEARCH;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_detect.sv
// Randomized stimulus checked each cycle against an event-level timing model.
module tb_vga_timing_detect;

  localparam int MAXV = 65535;
  localparam int M_SEARCH = 0, M_MEASURE = 1, M_VERIFY = 2, M_LOCK = 3;

  logic        clk = 1'b0;
  logic        reset, pix_en, hsync_in, vsync_in, de_in;
  logic [15:0] h_total, h_active, v_total, v_active;
  logic        locked, frame_start, line_start;

  always #5 clk = ~clk;

  vga_timing_detect dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .locked(locked), .frame_start(frame_start), .line_start(line_start)
  );

  int errors = 0, checks = 0;
  bit chk_on = 1'b0;
  bit gaps = 1'b0;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (line/frame events) ----------------
  int m_cur_len, m_cur_de, m_lines, m_act_lines, m_ref_len, m_last_len, m_last_act, m_mode;
  bit m_ref_vld, m_ok, m_lock, m_fs, m_ls, m_hp, m_vp;
  int m_cand[4];
  int m_out[4];

  function automatic int inc(input int v);
    return (v >= MAXV) ? MAXV : v + 1;
  endfunction

  task automatic model_reset();
    m_cur_len = 0; m_cur_de = 0; m_lines = 0; m_act_lines = 0; m_ref_len = 0;
    m_last_len = 0; m_last_act = 0; m_mode = M_SEARCH;
    m_ref_vld = 0; m_ok = 0; m_lock = 0; m_fs = 0; m_ls = 0; m_hp = 0; m_vp = 0;
    for (int i = 0; i < 4; i++) begin m_cand[i] = 0; m_out[i] = 0; end
  endtask

  task automatic frame_done(input int a, input int b, input int c, input int d, input bit ok);
    bit eq_c, eq_o;
    eq_c = (a == m_cand[0]) && (b == m_cand[1]) && (c == m_cand[2]) && (d == m_cand[3]);
    eq_o = (a == m_out[0]) && (b == m_out[1]) && (c == m_out[2]) && (d == m_out[3]);
    case (m_mode)
      M_SEARCH: m_mode = M_MEASURE;
      M_MEASURE: begin
        m_cand = '{a, b, c, d};
        if (ok) m_mode = M_VERIFY;
      end
      M_VERIFY: begin
        if (ok && eq_c) begin m_mode = M_LOCK; m_lock = 1; m_out = m_cand; end
        else m_cand = '{a, b, c, d};
      end
      default: begin
        if (!(ok && eq_o)) begin m_lock = 0; m_mode = M_VERIFY; m_cand = '{a, b, c, d}; end
      end
    endcase
  endtask

  task automatic model_step(input bit h, input bit v, input bit d);
    bit he, ve, sat;
    int lines_in_frame;
    he = !h && m_hp;
    ve = !v && m_vp;
    sat = (m_cur_len >= MAXV) || (m_cur_de >= MAXV) || (m_lines >= MAXV) || (m_act_lines >= MAXV);
    lines_in_frame = m_lines;
    m_ls = he;
    m_fs = ve;
    if (he) begin
      if (m_cur_de > 0) begin m_act_lines = inc(m_act_lines); m_last_act = m_cur_de; end
      if (!m_ref_vld) begin m_ref_len = m_cur_len; m_ref_vld = 1; end
      else if (m_cur_len != m_ref_len) m_ok = 0;
      if (!sat && m_mode == M_LOCK && m_cur_len != m_out[0]) begin m_lock = 0; m_mode = M_SEARCH; end
      m_last_len = m_cur_len;
      m_cur_len = 1;
      m_cur_de = d;
    end else begin
      m_cur_len = inc(m_cur_len);
      if (d) m_cur_de = inc(m_cur_de);
    end
    if (ve) begin
      if (!sat) frame_done(m_last_len, m_last_act, lines_in_frame, m_act_lines, m_ok);
      m_lines = he ? 1 : 0;
      m_act_lines = 0; m_ok = 1; m_ref_vld = 0; m_last_act = 0;
    end else if (he) begin
      m_lines = inc(m_lines);
    end
    if (sat) begin m_mode = M_SEARCH; m_lock = 0; end
    m_hp = h;
    m_vp = v;
  endtask

  // ---------------- model step + compare, every cycle ----------------
  int fs_total = 0, ls_total = 0, fs_since = 0, fs_at_lock = 0;
  bit prev_locked = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      else if (pix_en) model_step(hsync_in, vsync_in, de_in);
      else begin m_fs = 0; m_ls = 0; end
      if (reset) begin fs_since = 0; end
      else begin
        if (frame_start) begin fs_total++; fs_since++; end
        if (line_start) ls_total++;
        if (locked && !prev_locked) fs_at_lock = fs_since;
        if (!locked && prev_locked) fs_since = 0;
      end
      prev_locked = locked;
      if (chk_on)
        check("cycle", {h_total, h_active, v_total, v_active, locked, frame_start, line_start},
              {16'(m_out[0]), 16'(m_out[1]), 16'(m_out[2]), 16'(m_out[3]), m_lock, m_fs, m_ls});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit p, input bit h, input bit v, input bit d);
    @(negedge clk);
    #1;
    pix_en = p; hsync_in = h; vsync_in = v; de_in = d;
  endtask

  task automatic pix(input bit h, input bit v, input bit d);
    if (gaps)
      while ($urandom_range(0, 1) == 1)
        drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    drive(1'b1, h, v, d);
  endtask

  task automatic send_frame(input int hl, input int vl, input int hsw, input int vsw,
                            input int dx0, input int dw, input int dy0, input int dh,
                            input int bad_line, input int l0);
    for (int l = l0; l < vl; l++) begin
      int len;
      len = hl + ((l == bad_line) ? 1 : 0);
      for (int x = 0; x < len; x++)
        pix(x >= hsw, l >= vsw, (x >= dx0) && (x < dx0 + dw) && (l >= dy0) && (l < dy0 + dh));
    end
  endtask

  task automatic std_frames(input int n);
    for (int i = 0; i < n; i++) send_frame(20, 10, 3, 1, 5, 12, 2, 6, -1, 0);
  endtask

  task automatic check_std(input string tag);
    check({tag, "_h_total"}, 67'(h_total), 67'd20);
    check({tag, "_h_active"}, 67'(h_active), 67'd12);
    check({tag, "_v_total"}, 67'(v_total), 67'd10);
    check({tag, "_v_active"}, 67'(v_active), 67'd6);
    check({tag, "_locked"}, 67'(locked), 67'd1);
  endtask

  initial begin
    int fs0, ls0;
    reset = 1; pix_en = 0; hsync_in = 1; vsync_in = 1; de_in = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {h_total, h_active, v_total, v_active, locked, frame_start, line_start}, 67'd0);
    #1 reset = 0;
    chk_on = 1;

    // steady stream, continuous pix_en
    std_frames(5);
    check_std("steady");
    check("steady_fs_at_lock", 67'(fs_at_lock), 67'd3);
    fs0 = fs_total;
    std_frames(2);
    check("fs_per_200clk", 67'(fs_total - fs0), 67'd2);

    // same stream with pix_en gaps, from a fresh reset
    @(negedge clk); #1 reset = 1;
    @(negedge clk); #1 reset = 0;
    gaps = 1;
    std_frames(5);
    check_std("gapped");
    check("gapped_fs_at_lock", 67'(fs_at_lock), 67'd3);

    // one 21-clk line mid-frame, then clean frames
    send_frame(20, 10, 3, 1, 5, 12, 2, 6, 4, 0);
    check("bad_line_unlock", 67'(locked), 67'd0);
    std_frames(4);
    check_std("relock");
    check("relock_fs", 67'(fs_at_lock), 67'd3);
    gaps = 0;

    // switch to 24-clk lines / 11-line frames
    for (int i = 0; i < 5; i++) send_frame(24, 11, 3, 1, 5, 14, 2, 7, -1, 0);
    check("sw_h_total", 67'(h_total), 67'd24);
    check("sw_h_active", 67'(h_active), 67'd14);
    check("sw_v_total", 67'(v_total), 67'd11);
    check("sw_v_active", 67'(v_active), 67'd7);
    check("sw_locked", 67'(locked), 67'd1);
    check("sw_fs_at_lock", 67'(fs_at_lock), 67'd3);

    // dead sync: counters saturate
    fs0 = fs_total; ls0 = ls_total;
    for (int i = 0; i < 65540; i++) pix(1'b1, 1'b1, 1'b0);
    check("sat_locked", 67'(locked), 67'd0);
    check("sat_no_fs", 67'(fs_total - fs0), 67'd0);
    check("sat_no_ls", 67'(ls_total - ls0), 67'd0);
    std_frames(6);
    check_std("after_sat");

    // reset mid-frame while locked
    send_frame(20, 10, 3, 1, 5, 12, 2, 6, -1, 5);
    send_frame(20, 5, 3, 1, 5, 12, 2, 6, -1, 0);
    @(negedge clk); #1 reset = 1;
    #1 check("midreset_outputs", {h_total, h_active, v_total, v_active, locked, frame_start, line_start}, 67'd0);
    @(negedge clk); #1 reset = 0;
    send_frame(20, 10, 3, 1, 5, 12, 2, 6, -1, 5);
    std_frames(4);
    check_std("reacquire");
    check("reacquire_fs", 67'(fs_at_lock), 67'd3);

    // randomized timings, model-checked every cycle
    for (int c = 0; c < 3; c++) begin
      int hl, vl, hsw, vsw, dw, dh;
      hl = $urandom_range(16, 40); vl = $urandom_range(6, 14);
      hsw = $urandom_range(1, 4); vsw = $urandom_range(1, 2);
      dw = $urandom_range(1, hl - hsw - 2); dh = $urandom_range(1, vl - vsw - 1);
      gaps = 1'($urandom);
      for (int i = 0; i < 4; i++) send_frame(hl, vl, hsw, vsw, hsw + 1, dw, vsw, dh, -1, 0);
      check("rnd_h_total", 67'(h_total), 67'(hl));
      check("rnd_h_active", 67'(h_active), 67'(dw));
      check("rnd_v_total", 67'(v_total), 67'(vl));
      check("rnd_v_active", 67'(v_active), 67'(dh));
      check("rnd_locked", 67'(locked), 67'd1);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_detect.md
Name: vga_timing_detect

Overview:
- Receive-side counterpart of the VGA sync generators.
- Samples an incoming hsync/vsync/data-enable stream at pixel rate and measures line length, active pixels per line, lines per frame and active lines per frame.
- Declares lock once two consecutive frames measure identically.
- Sits at the front of the video capture path and feeds frame/line strobes plus measured timing to downstream capture and status logic.

Parameters:
- SYNC_POL, 0, active level of hsync_in/vsync_in (0 = active-low, matching our generators).
- CNT_W, 16, width of all counters and measurement outputs.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pix_en  input  1  pixel strobe; all inputs are sampled only on clk edges where pix_en=1
- hsync_in  input  1  incoming horizontal sync
- vsync_in  input  1  incoming vertical sync
- de_in  input  1  incoming data enable (visible pixel)
- h_total  output  CNT_W  locked pixels per line
- h_active  output  CNT_W  locked de pixels per line
- v_total  output  CNT_W  locked lines per frame
- v_active  output  CNT_W  locked lines containing de per frame
- locked  output  1  timing stable
- frame_start  output  1  one-clk pulse on each vsync leading edge
- line_start  output  1  one-clk pulse on each hsync leading edge

Behaviour:
Reset:
- All outputs 0; state SEARCH; all counters and candidates 0.

Sampling and edges:
- Sampling: on pix_en=1, hsync_in/vsync_in/de_in are registered (sample stage).
- Leading edge: previous sample inactive and current sample active (active = SYNC_POL).
- line_start/frame_start assert the clk after the sampling edge that detects the edge; pulses are exactly one clk wide, independent of pix_en.

Counting:
- hcnt increments per sample and restarts at 1 on an hsync edge.
- At an hsync edge, the line length is captured as the hcnt value before restart; de samples in the line are captured as line_active.
- Frame-consistency flag clears if any captured line length differs from the first line of the frame (the first line after a vsync edge is the reference).
- vcnt counts hsync edges since the last vsync edge.
- vact counts lines with line_active > 0.
- Simultaneous hsync and vsync edges: the line is closed first, then the frame is closed, and the new line counts as line 1 of the new frame.

Saturation:
- Any counter reaching all-ones saturates.
- Saturation forces state SEARCH and locked=0 (dead or missing sync).

State machine, evaluated at each vsync edge:
- SEARCH: first vsync edge -> MEASURE. Counters restart; nothing is captured.
- MEASURE: next vsync edge -> latch candidate {line length, line_active of last line, vcnt, vact}.
  - Consistency flag set -> VERIFY.
  - Otherwise -> stay MEASURE.
- VERIFY: next vsync edge compares the new frame to the candidate.
  - Equal and consistent -> LOCKED. Copy the candidate to the h_/v_ outputs and set locked=1 the clk after the edge.
  - Otherwise -> load the new candidate and stay VERIFY.
- LOCKED, per line: if a captured line length != h_total -> locked=0, -> SEARCH, outputs hold their last values.
- LOCKED, per frame: if the frame differs from the outputs -> locked=0, -> VERIFY with the new candidate.
- Outputs change only on entry to LOCKED.

Reset mid-operation:
- Returns immediately to the reset values; frames in progress are discarded.

pix_en:
- When pix_en=0 nothing advances.
- Edges spanning gaps in pix_en are detected normally.

Test Plan:
- Steady stream (pix_en=1): hsync active-low 3 clk, line 20 clk, 12 de per line; frame 10 lines, sync 1 line, 6 active lines -> locked rises the clk after the 3rd vsync edge; h_total=20, h_active=12, v_total=10, v_active=6; one frame_start per 200 clks.
- Same stream with pix_en toggling 1/0 -> identical measured values; lock after 3 frames.
- After lock, a single line of length 21 -> locked=0 the clk after that hsync edge; relock after 3 further clean frames.
- After lock, switch to a 24-clk line / 11-line frame -> locked drops; after 3 more vsync edges locked=1 with h_total=24, v_total=11.
- Hold hsync and vsync inactive -> counters saturate at 16'hFFFF; state SEARCH, locked=0, no pulses.
- Assert reset mid-frame while locked -> all outputs 0 the same clk; lock is reacquired after 3 vsync edges.
